fmap_streamer: RTL
==================

Name: fmap_streamer

Overview:
Feature-map source that feeds the line-buffer chain. On a start pulse it reads one FIG_HEIGHT x FIG_WIDTH feature map from a block-RAM frame buffer in raster order, starting at a programmable base address. It emits one word per cycle on a din/in_valid style stream that drives line-buffer inputs directly. Issue is gated by the line buffers' ready (FIFO reset-busy clear) and by a downstream stall. It also marks row and frame boundaries for the window/PE control.

Parameters:
WORDWIDTH, 32, data word width
FIG_WIDTH, 28, pixels per row
FIG_HEIGHT, 28, rows per frame
ADDRLEN, 10, frame-buffer address width; must satisfy FIG_WIDTH*FIG_HEIGHT <= 2^ADDRLEN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to stream one frame; ignored unless idle
base_addr  in  ADDRLEN  frame start address; sampled on accepted start
ready  in  1  line-buffer chain ready (AND of all LineBuffer ready outputs)
stall  in  1  downstream hold; blocks new reads while high
mem_rd_en  out  1  frame-buffer read enable
mem_addr  out  ADDRLEN  frame-buffer read address
mem_rdata  in  WORDWIDTH  read data, valid exactly 1 cycle after mem_rd_en
dout  out  WORDWIDTH  streamed pixel
out_valid  out  1  dout valid; connects to LineBuffer in_valid
sol  out  1  qualifies dout as column 0
eol  out  1  qualifies dout as column FIG_WIDTH-1
last  out  1  qualifies dout as the final pixel of the frame
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, same cycle as the last out_valid

Behaviour:
- Reset: state IDLE. mem_rd_en, out_valid, sol, eol, last, busy, and done are 0. mem_addr and dout are 0. Counters are cleared.
- States: IDLE -> RUN on start. RUN -> DRAIN after the final read is issued. DRAIN -> IDLE when the final word is output, with done pulsed that cycle.
- Start accepted only in IDLE. Accept latches base_addr and clears col/row. busy goes high the next cycle.
- Issue condition in RUN: issue = ready & ~stall.
  - mem_rd_en = issue. mem_addr = base + row*FIG_WIDTH + col, held in an incrementing address register with no multiplier.
  - On issue, col increments. At col == FIG_WIDTH-1, col wraps to 0 and row increments.
  - The issue with row == FIG_HEIGHT-1 and col == FIG_WIDTH-1 is the final issue; the FSM moves to DRAIN.
- Pipeline: sideband flags (sol/eol/last) are computed at issue and delayed one stage alongside the read.
  - The cycle after a read, mem_rdata is registered into dout. out_valid, sol, eol, and last are registered from the delayed issue flags.
  - Latency: issue at cycle t -> out_valid at t+2. Sustained throughput is 1 word/cycle.
- stall or ~ready blocks only new issues. Up to 2 already-issued words still complete and are output; no skid buffer, since LineBuffer never back-pressures.
- out_valid is never asserted without a matching prior mem_rd_en. Exactly FIG_WIDTH*FIG_HEIGHT out_valid pulses occur per frame.
- A start arriving during RUN or DRAIN is ignored, with no queuing.
- Address arithmetic wraps modulo 2^ADDRLEN if base + size overflows; no error flag.
- Asynchronous reset mid-frame aborts immediately to the reset state, with no done pulse.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DRAIN) and a FRAME_SIZE = FIG_WIDTH*FIG_HEIGHT localparam helper. The package is shared with the window-control block that consumes sol/eol/last.
- One sub-module, fmap_raster_counter: col/row counters with wrap, the address register, and first/last-column and last-pixel flags. The FSM and output pipeline stay in the top module.

Test Plan:
- Config FIG_WIDTH=4, FIG_HEIGHT=3; memory[i] = i + 0x100; start with base_addr=0x010, ready=1, stall=0.
  - mem_addr runs 0x010..0x01B on consecutive cycles.
  - out_valid runs 12 consecutive cycles, starting 2 cycles after the first mem_rd_en, with dout = 0x110..0x11B.
  - sol on words 0, 4, and 8; eol on words 3, 7, and 11; last and done on word 11; busy then falls.
- Same config with stall high for 3 cycles after the 5th issue.
  - Exactly 2 in-flight words are still output; mem_rd_en is low for 3 cycles.
  - The stream resumes at addr 0x015; still 12 words total in order.
- ready low at start (FIFO reset busy for 5 cycles).
  - Start is accepted and busy=1, but there is no mem_rd_en until ready=1.
  - The first mem_addr equals base_addr.
- Second start pulse during RUN -> ignored. Exactly one done and 12 out_valid pulses; the next start after done streams a fresh frame.
- Assert rst_n low after the 6th out_valid.
  - All outputs are 0 asynchronously and state is IDLE; no done pulse.
  - A subsequent start streams the full 12 words from base.
- base_addr = 2^ADDRLEN - 2 -> mem_addr sequence is 0x3FE, 0x3FF, 0x000, 0x001, ... (ADDRLEN=10), with data order intact.

Source files
------------

// File: rtl/fmap_streamer_pkg.sv
// Shared definitions for the feature-map streamer and the window-control
// logic that consumes its sol/eol/last sideband.
package fmap_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fmap_state_e;

  localparam int DEF_FIG_WIDTH  = 28;
  localparam int DEF_FIG_HEIGHT = 28;

  function automatic int frame_size(input int fig_width, input int fig_height);
    return fig_width * fig_height;
  endfunction

  localparam int FRAME_SIZE = frame_size(DEF_FIG_WIDTH, DEF_FIG_HEIGHT);

endpackage

// File: rtl/fmap_raster_counter.sv
// Raster-order column/row counters plus the frame-buffer address register.
// The address register simply increments because raster order is linear.
module fmap_raster_counter #(
  parameter int FIG_WIDTH  = 28,
  parameter int FIG_HEIGHT = 28,
  parameter int ADDRLEN    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [ADDRLEN-1:0] base_i,
  input  logic               adv_i,
  output logic [ADDRLEN-1:0] addr_o,
  output logic               first_col_o,
  output logic               last_col_o,
  output logic               last_pix_o
);

  localparam int CW = (FIG_WIDTH  > 1) ? $clog2(FIG_WIDTH)  : 1;
  localparam int RW = (FIG_HEIGHT > 1) ? $clog2(FIG_HEIGHT) : 1;

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [ADDRLEN-1:0] addr_q, addr_d;

  assign first_col_o = (col_q == '0);
  assign last_col_o  = (col_q == CW'(FIG_WIDTH - 1));
  assign last_pix_o  = last_col_o && (row_q == RW'(FIG_HEIGHT - 1));
  assign addr_o      = addr_q;

  // Address overflow past 2^ADDRLEN wraps naturally in the adder.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (load_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = base_i;
    end else if (adv_i) begin
      addr_d = addr_q + ADDRLEN'(1);
      if (last_col_o) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/fmap_streamer.sv
// Streams one feature map from the frame buffer in raster order into the
// line-buffer chain, one word per cycle, with row/frame boundary flags.
module fmap_streamer
  import fmap_streamer_pkg::*;
#(
  parameter int WORDWIDTH  = 32,
  parameter int FIG_WIDTH  = 28,
  parameter int FIG_HEIGHT = 28,
  parameter int ADDRLEN    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDRLEN-1:0]   base_addr,
  input  logic                 ready,
  input  logic                 stall,
  output logic                 mem_rd_en,
  output logic [ADDRLEN-1:0]   mem_addr,
  input  logic [WORDWIDTH-1:0] mem_rdata,
  output logic [WORDWIDTH-1:0] dout,
  output logic                 out_valid,
  output logic                 sol,
  output logic                 eol,
  output logic                 last,
  output logic                 busy,
  output logic                 done
);

  // Stream handshake: out_valid qualifies dout for exactly one cycle; there
  // is no ready on the output side, so stall/ready only gate new reads and
  // words already in flight always emerge two cycles after their read.

  fmap_state_e state_q, state_d;

  logic accept, issue;
  logic first_col, last_col, last_pix;

  logic                 rd_v_q, rd_sol_q, rd_eol_q, rd_last_q;
  logic                 out_valid_q, sol_q, eol_q, last_q;
  logic [WORDWIDTH-1:0] dout_q;

  assign accept = (state_q == ST_IDLE) && start;
  assign issue  = (state_q == ST_RUN) && ready && !stall;

  fmap_raster_counter #(
    .FIG_WIDTH (FIG_WIDTH),
    .FIG_HEIGHT(FIG_HEIGHT),
    .ADDRLEN   (ADDRLEN)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .base_i     (base_addr),
    .adv_i      (issue),
    .addr_o     (mem_addr),
    .first_col_o(first_col),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (out_valid_q && last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Stage 1 tracks the read in flight; stage 2 captures the returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v_q      <= 1'b0;
      rd_sol_q    <= 1'b0;
      rd_eol_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      last_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      rd_v_q      <= issue;
      rd_sol_q    <= issue && first_col;
      rd_eol_q    <= issue && last_col;
      rd_last_q   <= issue && last_pix;
      out_valid_q <= rd_v_q;
      sol_q       <= rd_sol_q;
      eol_q       <= rd_eol_q;
      last_q      <= rd_last_q;
      if (rd_v_q) dout_q <= mem_rdata;
    end
  end

  assign mem_rd_en = issue;
  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign sol       = sol_q;
  assign eol       = eol_q;
  assign last      = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && out_valid_q && last_q;

endmodule
